// File: rtl/br_pkg.sv
// Shared definitions for branch resolution: condition codes, resolver FSM states, reset PC.
package br_pkg;

  typedef enum logic [3:0] {
    COND_NEVER  = 4'h0,
    COND_EQ     = 4'h1,
    COND_NE     = 4'h2,
    COND_LT     = 4'h3,
    COND_GE     = 4'h4,
    COND_GT     = 4'h5,
    COND_LE     = 4'h6,
    COND_LTU    = 4'h7,
    COND_GEU    = 4'h8,
    COND_LTZ    = 4'h9,
    COND_GEZ    = 4'hA,
    COND_ALWAYS = 4'hB
  } cond_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Redirect PC value seen out of reset; sliced down to the configured width.
  localparam logic [63:0] RESET_PC = 64'h0;

endpackage

// File: rtl/br_cond_eval.sv
// Condition evaluation: cond code + ALU flags -> taken, purely combinational (0 cycles).
// Codes 4'hC..4'hF are reserved and resolve to not-taken.
module br_cond_eval
  import br_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic       cf,
  output logic       taken
);

  logic lt;
  assign lt = sf ^ of;

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ:     taken = zf;
      COND_NE:     taken = ~zf;
      COND_LT:     taken = lt;
      COND_GE:     taken = ~lt;
      COND_GT:     taken = ~zf & ~lt;
      COND_LE:     taken = zf | lt;
      COND_LTU:    taken = ~cf;
      COND_GEU:    taken = cf;
      COND_LTZ:    taken = sf;
      COND_GEZ:    taken = ~sf;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_resolve.sv
// Branch resolver: on a mispredict, redirect + flush one cycle after accept; ready low while flushing.
// Stall blocks acceptance only; BR_RESOLVE_STATS_EN adds saturating branch/mispredict counters.
module br_resolve
  import br_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic [3:0]       cond,
  input  logic             zf,
  input  logic             sf,
  input  logic             of,
  input  logic             cf,
  input  logic             pred_taken,
  input  logic [WIDTH-1:0] pc_next,
  input  logic [WIDTH-1:0] target,
  output logic             ready,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush
`ifdef BR_RESOLVE_STATS_EN
  ,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
`endif
);

  state_e     state;
  logic [3:0] flush_cnt;
  logic       taken;
  logic       accept;
  logic       mispredict;

  br_cond_eval u_cond_eval (
    .cond  (cond),
    .zf    (zf),
    .sf    (sf),
    .of    (of),
    .cf    (cf),
    .taken (taken)
  );

  assign ready      = (state == ST_IDLE);
  assign accept     = valid_in & ready & ~stall;
  assign mispredict = taken ^ pred_taken;

  // The flush countdown runs independently of stall; the cycle it reads 1 is the last flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      flush_cnt      <= 4'd0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= RESET_PC[WIDTH-1:0];
    end else begin
      case (state)
        ST_IDLE: begin
          redirect_valid <= 1'b0;
          if (accept && mispredict) begin
            state          <= ST_FLUSH;
            flush_cnt      <= 4'(FLUSH_CYCLES);
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= taken ? target : pc_next;
          end
        end
        ST_FLUSH: begin
          redirect_valid <= 1'b0;
          flush_cnt      <= flush_cnt - 4'd1;
          if (flush_cnt == 4'd1) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef BR_RESOLVE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (accept) begin
      if (br_count != '1)
        br_count <= br_count + 1'b1;
      if (mispredict && (mispred_count != '1))
        mispred_count <= mispred_count + 1'b1;
    end
  end
`endif

endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter WIDTH, default 16, PC/target width in bits.
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles flush stays asserted after a mispredict; legal range 1..15.
REQ-003 Parameter CNT_W, default 16, statistics counter width.
REQ-004 clk  in  1  sole clock, rising edge; reset is asynchronous and active-high.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 valid_in  in  1  branch/jump instruction presented this cycle.
REQ-007 stall  in  1  pipeline stall; blocks acceptance.
REQ-008 cond  in  4  condition code (encoding in REQ-015).
REQ-009 zf, sf, of, cf  in  1 each  ALU zero, sign, overflow and carry flags for the presented instruction.
REQ-010 pred_taken  in  1  fetch-stage prediction for the presented instruction.
REQ-011 pc_next, target  in  WIDTH each  fall-through PC and taken target.
REQ-012 ready  out  1  high when valid_in can be accepted.
REQ-013 redirect_valid, redirect_pc  out  1, WIDTH  registered fetch redirect.
REQ-014 flush  out  1  squash younger pipeline stages.

Function
REQ-015 cond encodings, taken when:
- 0000 never
- 0001 eq: zf
- 0010 ne: ~zf
- 0011 lt: sf^of
- 0100 ge: ~(sf^of)
- 0101 gt: ~zf & ~(sf^of)
- 0110 le: zf | (sf^of)
- 0111 ltu: ~cf
- 1000 geu: cf
- 1001 ltz: sf
- 1010 gez: ~sf
- 1011 always
- 1100..1111 reserved, never taken.
REQ-016 Accept = valid_in & ready & ~stall; no state or output changes on cycles without accept, except the flush countdown.
REQ-017 On accept, taken is evaluated combinationally from the same-cycle flags; mispredict = taken XOR pred_taken.
REQ-018 FSM states: IDLE and FLUSH; ready = (state == IDLE).
REQ-019 IDLE, accept with mispredict: next cycle redirect_valid=1 for exactly one cycle; redirect_pc = taken ? target : pc_next; state goes to FLUSH; flush counter loads FLUSH_CYCLES.
REQ-020 IDLE, accept without mispredict: redirect_valid stays 0; state stays IDLE.
REQ-021 FLUSH: flush=1, counter decrements each cycle regardless of stall; the cycle the counter reads 1 is the last flush cycle, and the state returns to IDLE next.
REQ-022 In FLUSH, valid_in is ignored and never accepted.
REQ-023 redirect_valid rises in the same cycle flush first rises, i.e. one cycle after accept.
REQ-024 redirect_pc holds its last value when redirect_valid=0.

Reset
REQ-025 rst asserted at any time, including mid-FLUSH, forces within the same cycle: state=IDLE, counter=0, redirect_valid=0, redirect_pc=0, flush=0, ready=1, and any statistics counters=0.
REQ-026 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro BR_RESOLVE_STATS_EN defined: outputs br_count and mispred_count (CNT_W each) are present.
- br_count increments on every accept.
- mispred_count increments on every mispredicted accept.
- Both saturate at all-ones.
REQ-028 Macro BR_RESOLVE_STATS_EN undefined: these ports and registers do not exist; all other behaviour is identical.

Structure
REQ-029 Shared package br_pkg holds the cond encodings, FSM state encoding and the reset PC constant.
REQ-030 Sub-module br_cond_eval (purely combinational; cond + flags -> taken) is instantiated once.

Verification
REQ-031 cond=0001, zf=1, pred_taken=0, target=0x0040 -> next cycle redirect_valid=1, redirect_pc=0x0040; flush=1 for exactly 2 cycles; ready=0 for those 2 cycles.
REQ-032 cond=0011, sf=1, of=1, pred_taken=0 -> not taken, no mispredict, no redirect, no flush; back-to-back accepts succeed on consecutive cycles.
REQ-033 Mispredict accepted, then valid_in held high during FLUSH -> no second redirect; the next accept occurs only in the first IDLE cycle.
REQ-034 valid_in=1 with stall=1 and a would-mispredict -> nothing happens; drop stall next cycle -> redirect one cycle later.
REQ-035 rst pulsed during the second flush cycle -> flush=0, ready=1 and redirect_valid=0 immediately, without waiting for a clock edge.
REQ-036 With BR_RESOLVE_STATS_EN and CNT_W=4: 20 mispredicting branches -> mispred_count=15 (saturated) and br_count=15.
